// File: rtl/ga_pe_pipe.sv
// Two-stage pipelined genetic-algorithm PE: crossover of two parent chromosomes
// followed by saturating +/-1 mutation. Per-lane Galois LFSRs drive all random decisions.
`default_nettype none

module ga_pe_pipe #(
  parameter int          GENE_W    = 8,
  parameter int          NUM_GENES = 4,
  parameter int          PROB_W    = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [GENE_W*NUM_GENES-1:0]   parent_gene0,
  input  logic [GENE_W*NUM_GENES-1:0]   parent_gene1,
  input  logic                          mode,
  input  logic                          bias,
  input  logic [PROB_W-1:0]             co_prob,
  input  logic [PROB_W-1:0]             perturb_prob,
  input  logic                          seed_load,
  input  logic [15:0]                   seed,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [GENE_W*NUM_GENES-1:0]   child_gene
);

  localparam int          IDX_W     = $clog2(NUM_GENES);
  localparam int          CHROM_W   = GENE_W * NUM_GENES;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [GENE_W-1:0] GENE_ONE = {{(GENE_W-1){1'b0}}, 1'b1};

  function automatic logic [15:0] lane_seed(input logic [15:0] base, input int lane);
    logic [15:0] s;
    s = base + (16'(lane) * 16'h1111);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  function automatic logic hit(input logic [PROB_W-1:0] p, input logic [PROB_W-1:0] x);
    return (p == {PROB_W{1'b1}}) || (x < p);
  endfunction

  logic [15:0]          lfsr_q [NUM_GENES];
  logic [15:0]          lfsr_d [NUM_GENES];
  logic                 s1_valid_q;
  logic [CHROM_W-1:0]   s1_genes_q;
  logic [NUM_GENES-1:0] s1_mut_q;
  logic                 s1_bias_q;
  logic                 s2_valid_q;
  logic [CHROM_W-1:0]   child_q;

  logic                 accept;
  logic                 s1_ready;
  logic                 s2_ready;
  logic [IDX_W-1:0]     cut;
  logic [CHROM_W-1:0]   xover;
  logic [NUM_GENES-1:0] mut_flag;
  logic [CHROM_W-1:0]   mutated;

  assign s2_ready  = !s2_valid_q || out_ready;
  assign s1_ready  = !s1_valid_q || s2_ready;
  assign in_ready  = s1_ready;
  assign accept    = in_valid && s1_ready;
  assign out_valid = s2_valid_q;
  assign child_gene = child_q;
  assign cut       = lfsr_q[0][IDX_W-1:0];

  // All decisions below read the pre-advance LFSR state.
  for (genvar i = 0; i < NUM_GENES; i++) begin : g_lane
    localparam logic [IDX_W:0] LANE_IDX = (IDX_W+1)'(i);
    logic              take_p1;
    logic [GENE_W-1:0] g;

    assign take_p1 = mode ? (LANE_IDX >= {1'b0, cut})
                          : hit(co_prob, lfsr_q[i][PROB_W-1:0]);
    assign xover[GENE_W*i +: GENE_W] = take_p1 ? parent_gene1[GENE_W*i +: GENE_W]
                                               : parent_gene0[GENE_W*i +: GENE_W];
    assign mut_flag[i] = hit(perturb_prob, lfsr_q[i][15 -: PROB_W]);

    assign g = s1_genes_q[GENE_W*i +: GENE_W];
    assign mutated[GENE_W*i +: GENE_W] =
        !s1_mut_q[i] ? g :
        s1_bias_q    ? ((g == {GENE_W{1'b1}}) ? g : g + GENE_ONE) :
                       ((g == {GENE_W{1'b0}}) ? g : g - GENE_ONE);
  end

  // Reseed wins over an advance in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_GENES; i++) begin
      if (seed_load)
        lfsr_d[i] = lane_seed(seed, i);
      else if (accept)
        lfsr_d[i] = {1'b0, lfsr_q[i][15:1]} ^ (lfsr_q[i][0] ? LFSR_MASK : 16'h0000);
      else
        lfsr_d[i] = lfsr_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_GENES; i++) lfsr_q[i] <= lane_seed(LFSR_SEED, i);
    end else begin
      for (int i = 0; i < NUM_GENES; i++) lfsr_q[i] <= lfsr_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_genes_q <= '0;
      s1_mut_q   <= '0;
      s1_bias_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      child_q    <= '0;
    end else begin
      if (s1_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_genes_q <= xover;
          s1_mut_q   <= mut_flag;
          s1_bias_q  <= bias;
        end
      end
      if (s2_ready) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) child_q <= mutated;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ga_pe_pipe.sv
// Scoreboard bench for ga_pe_pipe: directed vectors with hand-computed children,
// plus an independent LFSR reference model for the stall and reset-replay scenarios.
`default_nettype none

module tb_ga_pe_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] parent_gene0;
  logic [31:0] parent_gene1;
  logic        mode;
  logic        bias;
  logic [7:0]  co_prob;
  logic [7:0]  perturb_prob;
  logic        seed_load;
  logic [15:0] seed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] child_gene;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_log[$];
  logic [15:0] m_lfsr [4];

  ga_pe_pipe #(.GENE_W(8), .NUM_GENES(4), .PROB_W(8), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .parent_gene0(parent_gene0), .parent_gene1(parent_gene1),
    .mode(mode), .bias(bias), .co_prob(co_prob), .perturb_prob(perturb_prob),
    .seed_load(seed_load), .seed(seed),
    .out_valid(out_valid), .out_ready(out_ready), .child_gene(child_gene)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      got_log.push_back(child_gene);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_child got %h expected none", child_gene);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (child_gene !== e) begin
          errors++;
          $display("FAIL child got %h expected %h", child_gene, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, expv);
    end
  endtask

  function automatic logic [15:0] m_seed(input logic [15:0] base, input int lane);
    logic [15:0] s;
    s = base + 16'(lane * 'h1111);
    if (s == 0) s = 16'h0001;
    return s;
  endfunction

  task automatic m_reset(input logic [15:0] base);
    for (int i = 0; i < 4; i++) m_lfsr[i] = m_seed(base, i);
  endtask

  task automatic m_advance();
    for (int i = 0; i < 4; i++) begin
      if (m_lfsr[i][0]) m_lfsr[i] = (m_lfsr[i] >> 1) ^ 16'hB400;
      else              m_lfsr[i] = m_lfsr[i] >> 1;
    end
  endtask

  function automatic bit m_hit(input logic [7:0] p, input logic [7:0] x);
    if (p == 8'hFF) return 1'b1;
    return x < p;
  endfunction

  function automatic logic [31:0] m_child(input logic [31:0] a, input logic [31:0] b,
      input logic md, input logic bs, input logic [7:0] co, input logic [7:0] pp);
    logic [31:0] r;
    int cut, v;
    logic [15:0] l;
    cut = int'(m_lfsr[0] & 16'h0003);
    for (int i = 0; i < 4; i++) begin
      l = m_lfsr[i];
      if (md ? (i >= cut) : m_hit(co, l[7:0])) v = int'(b[8*i +: 8]);
      else                                     v = int'(a[8*i +: 8]);
      if (m_hit(pp, l[15:8])) begin
        v = bs ? v + 1 : v - 1;
        if (v > 255) v = 255;
        if (v < 0) v = 0;
      end
      r[8*i +: 8] = 8'(v);
    end
    return r;
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic md,
      input logic bs, input logic [7:0] co, input logic [7:0] pp, input logic [31:0] expv);
    int n;
    in_valid = 1'b1; parent_gene0 = a; parent_gene1 = b;
    mode = md; bias = bs; co_prob = co; perturb_prob = pp;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout got in_ready=0 expected 1");
        break;
      end
    end
    @(posedge clk);
    exp_q.push_back(expv);
    m_advance();
    #1;
    in_valid = 1'b0;
  endtask

  task automatic reseed(input logic [15:0] s);
    @(posedge clk); #1;
    seed_load = 1'b1; seed = s;
    @(posedge clk); #1;
    seed_load = 1'b0;
    m_reset(s);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic power_up_seq();
    out_ready = 1'b1;
    send(32'h04030201, 32'h08070605, 1'b0, 1'b0, 8'h00, 8'h00, 32'h04030201);
    @(negedge clk); check("latency_cycle1_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk); check("latency_cycle2_valid", {31'b0, out_valid}, 32'd1);
    drain();
    send(32'h04030201, 32'h08070605, 1'b0, 1'b0, 8'hFF, 8'h00, 32'h08070605);
    send(32'h11223344, 32'h55667788, 1'b0, 1'b1, 8'hFF, 8'h00, 32'h55667788);
    send(32'h99AABBCC, 32'hDDEEFF00, 1'b0, 1'b0, 8'hFF, 8'h00, 32'hDDEEFF00);
    send(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 1'b1, 8'hFF, 8'h00, 32'hF0F0F0F0);
    @(negedge clk); check("b2b_valid_2", {31'b0, out_valid}, 32'd1);
    @(negedge clk); check("b2b_valid_3", {31'b0, out_valid}, 32'd1);
    @(negedge clk); check("b2b_idle",    {31'b0, out_valid}, 32'd0);
    drain();
  endtask

  initial begin
    logic [31:0] e, hold;
    int n0, base;
    rst = 1'b0; in_valid = 1'b0; parent_gene0 = '0; parent_gene1 = '0;
    mode = 1'b0; bias = 1'b0; co_prob = '0; perturb_prob = '0;
    seed_load = 1'b0; seed = '0; out_ready = 1'b1;
    m_reset(16'hACE1);
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_child", child_gene, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);

    power_up_seq();
    n0 = got_log.size();

    // Saturating mutation, both directions.
    send(32'h04FF02FF, 32'h08070605, 1'b0, 1'b1, 8'h00, 8'hFF, 32'h05FF03FF);
    send(32'hAABBCCDD, 32'h08070605, 1'b0, 1'b0, 8'h00, 8'hFF, 32'hA9BACBDC);
    send(32'h00000000, 32'h08070605, 1'b0, 1'b0, 8'h00, 8'hFF, 32'h00000000);
    drain();

    // Single-point crossover with a known cut.
    reseed(16'h0002);
    send(32'h04030201, 32'h08070605, 1'b1, 1'b0, 8'h00, 8'h00, 32'h08070201);
    drain();

    // Backpressure: two accepted, third held off, output stable.
    out_ready = 1'b0;
    e = m_child(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, 8'h80, 8'h40);
    send(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, 8'h80, 8'h40, e);
    e = m_child(32'hFF00FF00, 32'h00FF00FF, 1'b0, 1'b0, 8'h80, 8'h40);
    send(32'hFF00FF00, 32'h00FF00FF, 1'b0, 1'b0, 8'h80, 8'h40, e);
    in_valid = 1'b1; parent_gene0 = 32'h01020304; parent_gene1 = 32'hA0B0C0D0;
    mode = 1'b1; bias = 1'b0; co_prob = 8'h80; perturb_prob = 8'h40;
    @(negedge clk);
    check("stall_in_ready", {31'b0, in_ready}, 32'd0);
    hold = child_gene;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_child_stable", child_gene, hold);
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    e = m_child(32'h01020304, 32'hA0B0C0D0, 1'b1, 1'b0, 8'h80, 8'h40);
    send(32'h01020304, 32'hA0B0C0D0, 1'b1, 1'b0, 8'h80, 8'h40, e);
    drain();

    // Reset with both stages full, then replay the power-up sequence.
    out_ready = 1'b0;
    e = m_child(32'h0BADF00D, 32'hDEADBEEF, 1'b0, 1'b1, 8'h55, 8'hAA);
    send(32'h0BADF00D, 32'hDEADBEEF, 1'b0, 1'b1, 8'h55, 8'hAA, e);
    e = m_child(32'hCAFEBABE, 32'h13579BDF, 1'b0, 1'b0, 8'h55, 8'hAA);
    send(32'hCAFEBABE, 32'h13579BDF, 1'b0, 1'b0, 8'h55, 8'hAA, e);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("async_reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("async_reset_child", child_gene, 32'h0);
    exp_q.delete();
    m_reset(16'hACE1);
    base = got_log.size();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    power_up_seq();
    check("replay_count", 32'(got_log.size() - base), 32'(n0));
    for (int i = 0; i < n0 && base + i < got_log.size(); i++)
      check("replay_child", got_log[base + i], got_log[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
